// File: rtl/fpu_res_station.sv
// fpu_res_station: four-entry FPU reservation station with CDB wakeup/bypass
// and lowest-index-first issue to a single FPU wrapper.
module fpu_res_station #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 3,
    parameter int ENTRIES    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic [4:0]            disp_opcode,
    input  logic [TAG_WIDTH-1:0]  disp_tag,
    input  logic [4:0]            disp_dest_reg,
    input  logic                  disp_rdy1,
    input  logic                  disp_rdy2,
    input  logic                  disp_rdy3,
    input  logic [DATA_WIDTH-1:0] disp_val1,
    input  logic [DATA_WIDTH-1:0] disp_val2,
    input  logic [DATA_WIDTH-1:0] disp_val3,
    input  logic [TAG_WIDTH-1:0]  disp_q1,
    input  logic [TAG_WIDTH-1:0]  disp_q2,
    input  logic [TAG_WIDTH-1:0]  disp_q3,
    input  logic                  cdb_bc_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_bc_tag,
    input  logic [DATA_WIDTH-1:0] cdb_bc_data,
    input  logic                  flush,
    input  logic                  fu_busy,
    output logic                  fu_start,
    output logic [4:0]            fu_opcode,
    output logic [DATA_WIDTH-1:0] fu_op1,
    output logic [DATA_WIDTH-1:0] fu_op2,
    output logic [DATA_WIDTH-1:0] fu_op3,
    output logic [TAG_WIDTH-1:0]  fu_tag,
    output logic [4:0]            fu_dest_reg,
    output logic [2:0]            occupancy
);
    localparam int IW = $clog2(ENTRIES);

    logic [ENTRIES-1:0]    valid;
    logic [4:0]            opcode [ENTRIES];
    logic [TAG_WIDTH-1:0]  tag    [ENTRIES];
    logic [4:0]            dest   [ENTRIES];
    logic [2:0]            rdy    [ENTRIES];
    logic [DATA_WIDTH-1:0] val    [ENTRIES][3];
    logic [TAG_WIDTH-1:0]  q      [ENTRIES][3];
    logic                  holdoff;

    logic [ENTRIES-1:0]    eligible;
    logic [IW-1:0]         free_idx, sel;
    logic                  dispatch, issue;
    logic [2:0]            d_rdy, in_rdy;
    logic [DATA_WIDTH-1:0] d_val [3];
    logic [DATA_WIDTH-1:0] in_val [3];
    logic [TAG_WIDTH-1:0]  d_q [3];

    assign d_rdy = {disp_rdy3, disp_rdy2, disp_rdy1};
    assign d_val = '{disp_val1, disp_val2, disp_val3};
    assign d_q   = '{disp_q1, disp_q2, disp_q3};

    assign disp_ready = ~&valid;
    assign dispatch   = disp_valid & disp_ready & ~flush;
    assign issue      = |eligible & ~fu_busy & ~holdoff & ~flush;

    // Descending scan so the lowest index wins for both allocation and selection.
    always_comb begin
        free_idx = '0;
        sel      = '0;
        eligible = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            eligible[i] = valid[i] & (&rdy[i]);
            if (!valid[i]) free_idx = IW'(i);
            if (eligible[i]) sel = IW'(i);
        end
    end

    // Operands whose producer broadcasts in the dispatch cycle are captured directly.
    always_comb begin
        in_rdy = '0;
        in_val = '{default: '0};
        for (int j = 0; j < 3; j++) begin
            in_rdy[j] = d_rdy[j] | (cdb_bc_valid & (d_q[j] == cdb_bc_tag));
            in_val[j] = (!d_rdy[j] && cdb_bc_valid && d_q[j] == cdb_bc_tag) ? cdb_bc_data : d_val[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= '0;
            fu_start    <= 1'b0;
            holdoff     <= 1'b0;
            occupancy   <= '0;
            fu_opcode   <= '0;
            fu_op1      <= '0;
            fu_op2      <= '0;
            fu_op3      <= '0;
            fu_tag      <= '0;
            fu_dest_reg <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                opcode[i] <= '0;
                tag[i]    <= '0;
                dest[i]   <= '0;
                rdy[i]    <= '0;
                for (int j = 0; j < 3; j++) begin
                    val[i][j] <= '0;
                    q[i][j]   <= '0;
                end
            end
        end else if (flush) begin
            valid     <= '0;
            fu_start  <= 1'b0;
            holdoff   <= 1'b0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++)
                for (int j = 0; j < 3; j++)
                    if (valid[i] && !rdy[i][j] && cdb_bc_valid && q[i][j] == cdb_bc_tag) begin
                        rdy[i][j] <= 1'b1;
                        val[i][j] <= cdb_bc_data;
                    end
            if (issue) begin
                valid[sel]  <= 1'b0;
                fu_opcode   <= opcode[sel];
                fu_op1      <= val[sel][0];
                fu_op2      <= val[sel][1];
                fu_op3      <= val[sel][2];
                fu_tag      <= tag[sel];
                fu_dest_reg <= dest[sel];
            end
            if (dispatch) begin
                valid[free_idx]  <= 1'b1;
                opcode[free_idx] <= disp_opcode;
                tag[free_idx]    <= disp_tag;
                dest[free_idx]   <= disp_dest_reg;
                rdy[free_idx]    <= in_rdy;
                for (int j = 0; j < 3; j++) begin
                    val[free_idx][j] <= in_val[j];
                    q[free_idx][j]   <= d_q[j];
                end
            end
            fu_start  <= issue;
            holdoff   <= issue;
            occupancy <= occupancy + 3'(dispatch) - 3'(issue);
        end
    end
endmodule

// File: tb/tb_fpu_res_station.sv
// tb_fpu_res_station: directed and random stimulus against a behavioural station model,
// with a scoreboard queue of expected issue payloads popped by an independent monitor.
module tb_fpu_res_station;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        disp_valid = 0, disp_ready;
    logic [4:0]  disp_opcode = 0, disp_dest_reg = 0;
    logic [2:0]  disp_tag = 0;
    logic [2:0]  dr = 0;
    logic [31:0] dv [3] = '{0, 0, 0};
    logic [2:0]  dq [3] = '{0, 0, 0};
    logic        cdb_bc_valid = 0;
    logic [2:0]  cdb_bc_tag = 0;
    logic [31:0] cdb_bc_data = 0;
    logic        flush = 0, fu_busy = 0, fu_start;
    logic [4:0]  fu_opcode, fu_dest_reg;
    logic [31:0] fu_op1, fu_op2, fu_op3;
    logic [2:0]  fu_tag, occupancy;

    fpu_res_station dut (
        .clk(clk), .rst_n(rst_n), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_tag(disp_tag), .disp_dest_reg(disp_dest_reg),
        .disp_rdy1(dr[0]), .disp_rdy2(dr[1]), .disp_rdy3(dr[2]),
        .disp_val1(dv[0]), .disp_val2(dv[1]), .disp_val3(dv[2]),
        .disp_q1(dq[0]), .disp_q2(dq[1]), .disp_q3(dq[2]),
        .cdb_bc_valid(cdb_bc_valid), .cdb_bc_tag(cdb_bc_tag), .cdb_bc_data(cdb_bc_data),
        .flush(flush), .fu_busy(fu_busy), .fu_start(fu_start), .fu_opcode(fu_opcode),
        .fu_op1(fu_op1), .fu_op2(fu_op2), .fu_op3(fu_op3), .fu_tag(fu_tag),
        .fu_dest_reg(fu_dest_reg), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit          mv [4];
    logic [4:0]  mop [4], mdst [4];
    logic [2:0]  mtag [4];
    bit          mr [4][3];
    logic [31:0] md [4][3];
    logic [2:0]  mq [4][3];
    bit          m_start, m_hold;
    int          m_occ;
    logic [108:0] exp_q [$];
    logic [2:0]   seen [$];
    bit           prev_start;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_full();
        return mv[0] && mv[1] && mv[2] && mv[3];
    endfunction

    function automatic void model_reset();
        foreach (mv[i]) mv[i] = 0;
        m_start = 0; m_hold = 0; m_occ = 0;
        exp_q.delete();
    endfunction

    // One clock edge of the station, computed from the pre-edge model state and current inputs.
    function automatic void step();
        int iss = -1, fr = -1;
        bit dsp;
        if (!rst_n) begin model_reset(); return; end
        if (flush) begin
            foreach (mv[i]) mv[i] = 0;
            m_start = 0; m_hold = 0; m_occ = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (iss < 0 && mv[i] && mr[i][0] && mr[i][1] && mr[i][2]) iss = i;
            if (fr < 0 && !mv[i]) fr = i;
        end
        if (fu_busy || m_hold) iss = -1;
        dsp = disp_valid && fr >= 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
                if (mv[i] && !mr[i][j] && cdb_bc_valid && mq[i][j] == cdb_bc_tag) begin
                    mr[i][j] = 1; md[i][j] = cdb_bc_data;
                end
        if (iss >= 0) begin
            exp_q.push_back({mop[iss], mtag[iss], mdst[iss], md[iss][0], md[iss][1], md[iss][2]});
            mv[iss] = 0;
        end
        if (dsp) begin
            mv[fr] = 1; mop[fr] = disp_opcode; mtag[fr] = disp_tag; mdst[fr] = disp_dest_reg;
            for (int j = 0; j < 3; j++) begin
                mq[fr][j] = dq[j];
                mr[fr][j] = dr[j] || (cdb_bc_valid && dq[j] == cdb_bc_tag);
                md[fr][j] = (!dr[j] && cdb_bc_valid && dq[j] == cdb_bc_tag) ? cdb_bc_data : dv[j];
            end
        end
        m_start = iss >= 0;
        m_hold  = m_start;
        m_occ   = m_occ + int'(dsp) - int'(m_start);
    endfunction

    task automatic cyc();
        @(posedge clk);
        step();
        #1;
        chk("fu_start", fu_start, m_start);
        chk("occupancy", occupancy, m_occ);
        chk("disp_ready", disp_ready, !m_full());
    endtask

    task automatic idle();
        disp_valid = 0; cdb_bc_valid = 0; flush = 0;
    endtask

    task automatic set_disp(input logic [4:0] op, input logic [2:0] t, input logic [2:0] rdy, input logic [2:0] qt);
        disp_valid = 1; disp_opcode = op; disp_tag = t; disp_dest_reg = 5'($urandom); dr = rdy;
        for (int j = 0; j < 3; j++) begin dv[j] = $urandom; dq[j] = qt; end
    endtask

    task automatic bcast(input logic [2:0] t, input logic [31:0] d);
        cdb_bc_valid = 1; cdb_bc_tag = t; cdb_bc_data = d;
    endtask

    always @(negedge clk) begin
        if (fu_start) begin
            chk("issue_spacing", prev_start, 1'b0);
            seen.push_back(fu_tag);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_issue actual tag=%0h required none at %0t", fu_tag, $time);
            end else
                chk("issue_payload", {fu_opcode, fu_tag, fu_dest_reg, fu_op1, fu_op2, fu_op3}, exp_q.pop_front());
        end
        prev_start = fu_start;
    end

    initial begin
        model_reset();
        cyc(); cyc();
        rst_n = 1;
        chk("reset_disp_ready", disp_ready, 1'b1);
        chk("reset_payload", {fu_opcode, fu_tag, fu_dest_reg, fu_op1, fu_op2, fu_op3}, '0);
        cyc();
        // Basic single issue
        set_disp(5'd3, 3'd2, 3'b111, 3'd0); cyc(); idle(); cyc();
        chk("t036_start", fu_start, 1'b1);
        chk("t036_tag", fu_tag, 3'd2);
        chk("t036_occ", occupancy, 3'd0);
        repeat (3) cyc();
        // Late wakeup of operand 2
        set_disp(5'd7, 3'd1, 3'b101, 3'd5); cyc(); idle(); cyc();
        bcast(3'd5, 32'h4040_0000); cyc(); idle();
        chk("t037_no_early_start", fu_start, 1'b0);
        cyc();
        chk("t037_start", fu_start, 1'b1);
        chk("t037_op2", fu_op2, 32'h4040_0000);
        repeat (3) cyc();
        // Fill while busy, then drain in index order
        fu_busy = 1;
        for (int k = 0; k < 5; k++) begin set_disp(5'd1, 3'(k), 3'b111, 3'd0); cyc(); end
        idle();
        chk("t038_full", disp_ready, 1'b0);
        chk("t038_occ", occupancy, 3'd4);
        seen.delete();
        fu_busy = 0;
        repeat (12) cyc();
        chk("t038_count", seen.size(), 4);
        if (seen.size() == 4) chk("t038_order", {seen[0], seen[1], seen[2], seen[3]}, {3'd0, 3'd1, 3'd2, 3'd3});
        // Dispatch-cycle bypass
        set_disp(5'd9, 3'd3, 3'b110, 3'd6); bcast(3'd6, 32'hdead_beef); cyc(); idle(); cyc();
        chk("t039_start", fu_start, 1'b1);
        chk("t039_op1", fu_op1, 32'hdead_beef);
        repeat (3) cyc();
        // Flush beats a concurrent dispatch
        fu_busy = 1;
        for (int k = 0; k < 3; k++) begin set_disp(5'd2, 3'(k), 3'b111, 3'd0); cyc(); end
        set_disp(5'd4, 3'd7, 3'b111, 3'd0); flush = 1; cyc(); idle(); fu_busy = 0;
        chk("t040_occ", occupancy, 3'd0);
        cyc(); cyc();
        chk("t040_no_start", fu_start, 1'b0);
        // Asynchronous reset with an eligible entry
        fu_busy = 1;
        set_disp(5'd5, 3'd4, 3'b111, 3'd0); cyc(); idle(); cyc();
        fu_busy = 0; rst_n = 0; #1; model_reset();
        chk("t041_start", fu_start, 1'b0);
        chk("t041_outs", {occupancy, fu_opcode, fu_tag, fu_dest_reg, fu_op1, fu_op2, fu_op3}, '0);
        cyc(); rst_n = 1; cyc();
        chk("t041_ready", disp_ready, 1'b1);
        // Random traffic
        for (int n = 0; n < 800; n++) begin
            disp_valid = ($urandom_range(0, 9) < 6);
            disp_opcode = 5'($urandom); disp_tag = 3'($urandom); disp_dest_reg = 5'($urandom);
            for (int j = 0; j < 3; j++) begin
                dr[j] = ($urandom_range(0, 9) < 6); dv[j] = $urandom; dq[j] = 3'($urandom);
            end
            cdb_bc_valid = ($urandom_range(0, 9) < 5); cdb_bc_tag = 3'($urandom); cdb_bc_data = $urandom;
            flush = ($urandom_range(0, 99) < 2);
            fu_busy = ($urandom_range(0, 9) < 3);
            cyc();
        end
        idle(); fu_busy = 0;
        repeat (4) cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_res_station.md
FPU_RES_STATION -- requirements
Module: fpu_res_station

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter TAG_WIDTH, default 3, ROB/CDB tag width.
REQ-003 Parameter ENTRIES, default 4, station depth, fixed at 4.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 disp_valid  in  1  dispatcher offers an FPU instruction.
REQ-007 disp_ready  out  1  at least one free entry.
REQ-008 disp_opcode  in  5  FPU operation code.
REQ-009 disp_tag, disp_dest_reg  in  TAG_WIDTH, 5  instruction tag and destination register.
REQ-010 disp_rdy1/2/3  in  1 each  operand n holds a value (1) or waits on a tag (0).
REQ-011 disp_val1/2/3  in  DATA_WIDTH each  operand values.
REQ-012 disp_q1/2/3  in  TAG_WIDTH each  producer tags.
REQ-013 cdb_bc_valid, cdb_bc_tag, cdb_bc_data  in  1, TAG_WIDTH, DATA_WIDTH  granted CDB broadcast.
REQ-014 flush  in  1  synchronous clear of all entries.
REQ-015 fu_busy  in  1  FPU wrapper busy.
REQ-016 fu_start  out  1  one-cycle issue pulse to the FPU wrapper.
REQ-017 fu_opcode, fu_op1/2/3, fu_tag, fu_dest_reg  out  5, DATA_WIDTH x3, TAG_WIDTH, 5  registered issue payload.
REQ-018 occupancy  out  3  count of valid entries, 0..4.

Function
REQ-019 Each entry SHALL hold: valid, opcode, tag, dest_reg, and per operand a ready bit, a value and a q tag.
REQ-020 disp_ready SHALL equal NOT (all four valid bits set), decoded from registered state only, independent of disp_valid.
REQ-021 On disp_valid && disp_ready && !flush, the lowest-index free entry SHALL be written at the clock edge.
REQ-022 Dispatch bypass: a dispatched operand with rdy=0 and q equal to cdb_bc_tag while cdb_bc_valid SHALL be stored ready with cdb_bc_data.
REQ-023 Wakeup: every valid entry operand with ready=0 and q==cdb_bc_tag while cdb_bc_valid SHALL become ready with cdb_bc_data at the edge.
REQ-024 An entry SHALL be eligible for issue only when valid and all three ready bits are set in registered state; an operand woken this edge becomes eligible the next cycle.
REQ-025 Issue condition: an eligible entry exists && !fu_busy && !holdoff && !flush.
REQ-026 Selection SHALL be the lowest-index eligible entry.
REQ-027 On issue, fu_start SHALL be 1 for exactly the next cycle, fu_* SHALL carry that entry's fields, and the entry's valid SHALL clear at the same edge.
REQ-028 holdoff SHALL be set for the one cycle after fu_start, blocking issue while wrapper busy rises; holdoff SHALL clear after one cycle.
REQ-029 fu_* payload SHALL hold its last value when fu_start=0.
REQ-030 Dispatch and issue in the same cycle SHALL both complete; an entry freed by issue SHALL be allocatable from the following cycle.
REQ-031 occupancy SHALL update each edge as +1 on dispatch, -1 on issue, net 0 when both occur.
REQ-032 flush SHALL, at the edge, clear all valid bits, fu_start, holdoff and occupancy; flush SHALL take priority over dispatch, wakeup and issue.
REQ-033 A CDB broadcast matching no waiting operand SHALL change no state.

Reset
REQ-034 While rst_n=0: all valid bits 0, fu_start 0, holdoff 0, occupancy 0, fu_opcode/fu_op1..3/fu_tag/fu_dest_reg 0; disp_ready therefore 1.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately, with no issue pulse produced.

Verification
REQ-036 Dispatch op=3, tag=2, all ready, fu_busy=0 -> fu_start high on the next cycle, fu_tag=2, occupancy returns to 0.
REQ-037 Dispatch tag=1 with rdy2=0, q2=5; broadcast tag 5 data 0x40400000 two cycles later -> fu_op2=0x40400000, fu_start rises one cycle after wakeup, not earlier.
REQ-038 Dispatch 5 ready ops with fu_busy=1 -> four accepted, disp_ready=0, occupancy=4; release fu_busy -> entries issue in index order 0,1,2,3 with at least 2 cycles between fu_start pulses.
REQ-039 Dispatch with rdy1=0, q1=6 in the same cycle as a CDB broadcast of tag 6 -> operand stored ready, issue on the following cycle.
REQ-040 Three entries valid, assert flush together with disp_valid -> occupancy=0, no fu_start, new instruction not stored.
REQ-041 Drop rst_n while an entry is eligible -> fu_start stays 0, all outputs 0, disp_ready=1 after reset release.
